// File: rtl/sccpu_mem_arb.sv
// Shares one single-port memory between the instruction-fetch port and the
// load/store data port, with data priority, a burst limit and an access timeout.
module sccpu_mem_arb #(
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic [1:0]  gnt,
  output logic        stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] BURST_LIM = 4'(MAX_DATA_BURST);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [3:0] dcount;
  logic [7:0] wcnt;
  logic       d_win;

  function automatic logic [3:0] sat_inc(input logic [3:0] x);
    return (x == 4'hF) ? x : x + 4'd1;
  endfunction

  // Data wins unless a fetch has been waiting through a full data burst.
  assign d_win = d_req & (~if_req | (dcount < BURST_LIM));
  assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      dcount   <= 4'd0;
      wcnt     <= 8'd0;
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= 32'd0;
      m_wdata  <= 32'd0;
      gnt      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if_valid <= 1'b0;
          d_valid  <= 1'b0;
          err      <= 1'b0;
          wcnt     <= 8'd0;
          if (d_win) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            gnt     <= 2'b10;
            dcount  <= if_req ? sat_inc(dcount) : 4'd0;
            state   <= BUSY;
          end else if (if_req) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= if_addr;
            m_wdata <= 32'd0;
            gnt     <= 2'b01;
            dcount  <= 4'd0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          wcnt <= wcnt + 8'd1;
          if (m_ready) begin
            m_req <= 1'b0;
            if (gnt[0])
              if_rdata <= m_rdata;
            else if (!m_we)
              d_rdata <= m_rdata;
            if_valid <= gnt[0];
            d_valid  <= gnt[1];
            state    <= RESP;
          end else if (wcnt == TO_LAST) begin
            // Abort: report completion with err, leave read data untouched.
            m_req    <= 1'b0;
            err      <= 1'b1;
            if_valid <= gnt[0];
            d_valid  <= gnt[1];
            state    <= RESP;
          end
        end
        RESP: begin
          if_valid <= 1'b0;
          d_valid  <= 1'b0;
          err      <= 1'b0;
          wcnt     <= 8'd0;
          gnt      <= 2'b00;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccpu_mem_arb.sv
// Directed bench for sccpu_mem_arb with a small behavioural memory whose
// response latency can be set or disabled.
module tb_sccpu_mem_arb;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'd0;
  logic        m_ready = 1'b0;
  logic [1:0]  gnt;
  logic        stall;

  int n_vec = 0;
  int n_err = 0;

  // memory model controls
  int lat = 1;
  bit mem_en = 1'b1;
  int bsy_cnt = 0;
  logic [31:0] mem [256];
  bit wr_vld [256];

  sccpu_mem_arb #(.MAX_DATA_BURST(4), .TIMEOUT(16)) dut (
    .clk(clk), .clr(clr),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .gnt(gnt), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h40) ? 32'h12345678 : {16'hC0DE, a[15:0]};
  endfunction

  // Memory answers lat cycles after m_req rises; stores update the array.
  always @(negedge clk) begin
    if (m_req) begin
      bsy_cnt = bsy_cnt + 1;
      m_ready = mem_en && (bsy_cnt == lat);
      m_rdata = wr_vld[m_addr[9:2]] ? mem[m_addr[9:2]] : init_val(m_addr);
      if (m_ready && m_we) begin
        mem[m_addr[9:2]]    = m_wdata;
        wr_vld[m_addr[9:2]] = 1'b1;
      end
    end else begin
      bsy_cnt = 0;
      m_ready = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mreq(input logic lvl, input string tag);
    int n;
    n = 0;
    while (m_req !== lvl && n < 64) begin
      tick();
      n++;
    end
    if (m_req !== lvl) chk(tag, 32'(m_req), 32'(lvl));
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!(if_valid || d_valid) && n < 64) begin
      tick();
      n++;
    end
    if (!(if_valid || d_valid)) chk(tag, 32'd0, 32'd1);
  endtask

  logic [1:0] exp_gnt [10];

  initial begin
    int cnt;
    int pulses;
    exp_gnt = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    // reset state
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_mreq", 32'(m_req), 32'd0);
    chk("rst_valid", 32'({if_valid, d_valid, err}), 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    clr = 1'b0;
    tick();

    // single fetch
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    chk("f_mreq", 32'(m_req), 32'd1);
    chk("f_maddr", m_addr, 32'h40);
    chk("f_mwe", 32'(m_we), 32'd0);
    chk("f_gnt", 32'(gnt), 32'd1);
    chk("f_stall_busy", 32'(stall), 32'd1);
    tick();
    chk("f_valid", 32'(if_valid), 32'd1);
    chk("f_rdata", if_rdata, 32'h12345678);
    chk("f_err", 32'(err), 32'd0);
    if_req = 1'b0;
    #1;
    chk("f_stall_after", 32'(stall), 32'd0);
    tick();
    chk("f_valid_once", 32'(if_valid), 32'd0);
    tick();

    // store then load
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFEF00D;
    wait_mreq(1'b1, "st_grant_timeout");
    chk("st_mwe", 32'(m_we), 32'd1);
    chk("st_mwdata", m_wdata, 32'hCAFEF00D);
    chk("st_maddr", m_addr, 32'h100);
    chk("st_gnt", 32'(gnt), 32'd2);
    wait_valid("st_valid_timeout");
    chk("st_dvalid", 32'(d_valid), 32'd1);
    chk("st_drdata_kept", d_rdata, 32'd0);
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b0;
    wait_mreq(1'b1, "ld_grant_timeout");
    chk("ld_mwe", 32'(m_we), 32'd0);
    wait_valid("ld_valid_timeout");
    chk("ld_drdata", d_rdata, 32'hCAFEF00D);
    d_req = 1'b0;
    tick();

    // contention: both requests held continuously
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      wait_mreq(1'b1, "ct_grant_timeout");
      chk($sformatf("ct_gnt%0d", i), 32'(gnt), 32'(exp_gnt[i]));
      if (i == 0) chk("ct_loser_stall", 32'(stall), 32'd1);
      wait_mreq(1'b0, "ct_done_timeout");
    end
    wait_valid("ct_last_valid_timeout");
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();
    chk("ct_if_rdata", if_rdata, 32'hC0DE0200);
    chk("ct_d_rdata", d_rdata, 32'hC0DE0300);

    // timeout on a fetch
    mem_en = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    wait_mreq(1'b1, "to_grant_timeout");
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!m_req) break;
      cnt++;
    end
    chk("to_busy_cycles", 32'(cnt), 32'd16);
    chk("to_valid", 32'(if_valid), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rdata_kept", if_rdata, 32'hC0DE0200);
    if_req = 1'b0;
    tick();
    chk("to_err_clear", 32'({err, if_valid}), 32'd0);
    tick();

    // ready in the timeout cycle wins
    mem_en = 1'b1; lat = 16;
    if_req = 1'b1;
    wait_mreq(1'b1, "tr_grant_timeout");
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!m_req) break;
      cnt++;
    end
    chk("tr_busy_cycles", 32'(cnt), 32'd16);
    chk("tr_valid", 32'(if_valid), 32'd1);
    chk("tr_err", 32'(err), 32'd0);
    chk("tr_rdata", if_rdata, 32'h12345678);
    if_req = 1'b0;
    lat = 1;
    tick(); tick();

    // reset mid-access
    mem_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    wait_mreq(1'b1, "rm_grant_timeout");
    tick();
    clr = 1'b1; d_req = 1'b0;
    tick();
    chk("rm_mreq", 32'(m_req), 32'd0);
    chk("rm_gnt", 32'(gnt), 32'd0);
    chk("rm_no_valid", 32'({d_valid, err}), 32'd0);
    chk("rm_drdata", d_rdata, 32'd0);
    clr = 1'b0; mem_en = 1'b1;
    tick();
    chk("rm_no_valid_late", 32'(d_valid), 32'd0);
    d_req = 1'b1;
    wait_valid("rm_fresh_timeout");
    chk("rm_fresh_rdata", d_rdata, 32'hCAFEF00D);
    chk("rm_fresh_err", 32'(err), 32'd0);
    d_req = 1'b0;
    tick();

    // request withdrawn while busy
    lat = 3;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    wait_mreq(1'b1, "wd_grant_timeout");
    d_req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (d_valid) pulses++;
    end
    chk("wd_pulses", 32'(pulses), 32'd1);
    chk("wd_rdata", d_rdata, 32'hC0DE0104);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
